led_blink_driver: RTL and testbench

Output-side companion to the debounced switch input path. It converts a single-cycle event pulse into a human-visible LED pattern of N on/off blinks. While the pattern runs it reports busy, and it emits a one-cycle done pulse when the pattern finishes. It sits between event logic (for example a debounced button-release edge) and a board LED pin.

---
 rtl/led_blink_driver.sv | 108 ++++++++++
 tb/tb_led_blink_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_driver.sv
// Turns a one-cycle start pulse into N visible LED blinks (ON then OFF phase of
// CLKS_PER_PHASE cycles each), with registered busy and a one-cycle done pulse.
module led_blink_driver #(
   parameter int CLKS_PER_PHASE = 2500000
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Start,
   input  logic [3:0] i_Count,
   output logic       o_LED,
   output logic       o_Busy,
   output logic       o_Done,
   output logic [1:0] o_State
);

   localparam int PW = (CLKS_PER_PHASE > 1) ? $clog2(CLKS_PER_PHASE) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_PHASE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] phase, phase_n;
   logic [3:0]    blink, blink_n;
   logic [3:0]    n_lat, n_lat_n;
   logic          led_n, busy_n, done_n;
   logic [3:0]    blink_inc;

   assign blink_inc = blink + 4'd1;
   assign o_State   = state;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state  <= IDLE;
         phase  <= '0;
         blink  <= '0;
         n_lat  <= '0;
         o_LED  <= 1'b0;
         o_Busy <= 1'b0;
         o_Done <= 1'b0;
      end else begin
         state  <= state_n;
         phase  <= phase_n;
         blink  <= blink_n;
         n_lat  <= n_lat_n;
         o_LED  <= led_n;
         o_Busy <= busy_n;
         o_Done <= done_n;
      end
   end

   // Outputs are computed as next-state values so they line up with the state register.
   always_comb begin
      state_n = state;
      phase_n = phase;
      blink_n = blink;
      n_lat_n = n_lat;
      led_n   = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (i_Start && (i_Count != 4'd0)) begin
               n_lat_n = i_Count;
               phase_n = '0;
               blink_n = '0;
               state_n = ON;
               led_n   = 1'b1;
               busy_n  = 1'b1;
            end
         end
         ON: begin
            busy_n = 1'b1;
            if (phase == PHASE_LAST) begin
               phase_n = '0;
               state_n = OFF;
            end else begin
               phase_n = phase + 1'b1;
               led_n   = 1'b1;
            end
         end
         OFF: begin
            busy_n = 1'b1;
            if (phase == PHASE_LAST) begin
               phase_n = '0;
               blink_n = blink_inc;
               if (blink_inc == n_lat) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = ON;
                  led_n   = 1'b1;
               end
            end else begin
               phase_n = phase + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver using three instances (P=4, P=2, P=1).
// Inputs change and outputs are sampled on the falling edge; index k means "after rising edge Ek".
module tb_led_blink_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, start2 = 1'b0, start1 = 1'b0;
   logic [3:0] count4 = 4'd0, count2 = 4'd0, count1 = 4'd0;
   logic       led4, busy4, done4;
   logic       led2, busy2, done2;
   logic       led1, busy1, done1;
   logic [1:0] st4, st2, st1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   led_blink_driver #(.CLKS_PER_PHASE(4)) dut4 (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start4), .i_Count(count4),
      .o_LED(led4), .o_Busy(busy4), .o_Done(done4), .o_State(st4));
   led_blink_driver #(.CLKS_PER_PHASE(2)) dut2 (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start2), .i_Count(count2),
      .o_LED(led2), .o_Busy(busy2), .o_Done(done2), .o_State(st2));
   led_blink_driver #(.CLKS_PER_PHASE(1)) dut1 (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start1), .i_Count(count1),
      .o_LED(led1), .o_Busy(busy1), .o_Done(done1), .o_State(st1));

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start4 = 1'b1; count4 = 4'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({led4, busy4, done4, st4} !== 5'b0) begin
         n_fail++; $display("FAIL reset_p4 k=- got=%b exp=%b", {led4, busy4, done4, st4}, 5'b0);
      end
      n_checks++;
      if ({led2, busy2, done2, st2} !== 5'b0) begin
         n_fail++; $display("FAIL reset_p2 k=- got=%b exp=%b", {led2, busy2, done2, st2}, 5'b0);
      end
      n_checks++;
      if ({led1, busy1, done1, st1} !== 5'b0) begin
         n_fail++; $display("FAIL reset_p1 k=- got=%b exp=%b", {led1, busy1, done1, st1}, 5'b0);
      end
      rst = 1'b0; start4 = 1'b0; count4 = 4'd0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if ({led4, busy4, done4} !== 3'b000) begin
            n_fail++; $display("FAIL reset_start_same_cycle got=%b exp=%b", {led4, busy4, done4}, 3'b000);
         end
      end
   endtask

   task automatic test_basic();
      logic el, eb, ed;
      @(negedge clk);
      start4 = 1'b1; count4 = 4'd3;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         start4 = 1'b0;
         el = (k < 24) && ((k % 8) < 4);
         eb = (k < 24);
         ed = (k == 24);
         n_checks++;
         if ({led4, busy4, done4} !== {el, eb, ed}) begin
            n_fail++; $display("FAIL basic_p4 k=%0d led/busy/done got=%b exp=%b", k, {led4, busy4, done4}, {el, eb, ed});
         end
      end
   endtask

   task automatic test_zero_count();
      @(negedge clk);
      start4 = 1'b1; count4 = 4'd0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         start4 = 1'b0;
         n_checks++;
         if ({led4, busy4, done4} !== 3'b000) begin
            n_fail++; $display("FAIL zero_count k=%0d got=%b exp=%b", k, {led4, busy4, done4}, 3'b000);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic el, eb, ed;
      @(negedge clk);
      start4 = 1'b1; count4 = 4'd2;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         start4 = 1'b0;
         if (k == 4) begin
            start4 = 1'b1; count4 = 4'd5;
         end
         if (k == 8) count4 = 4'd9;
         el = (k < 16) && ((k % 8) < 4);
         eb = (k < 16);
         ed = (k == 16);
         n_checks++;
         if ({led4, busy4, done4} !== {el, eb, ed}) begin
            n_fail++; $display("FAIL start_while_busy k=%0d got=%b exp=%b", k, {led4, busy4, done4}, {el, eb, ed});
         end
      end
      count4 = 4'd0;
   endtask

   task automatic test_reset_mid();
      logic el, eb, ed;
      int j;
      @(negedge clk);
      start4 = 1'b1; count4 = 4'd3;
      for (int k = 0; k < 41; k++) begin
         @(posedge clk);
         @(negedge clk);
         start4 = 1'b0;
         if (k == 5) rst = 1'b1;
         if (k == 6) rst = 1'b0;
         if (k == 9) begin
            start4 = 1'b1; count4 = 4'd3;
         end
         if (k < 6) begin
            el = (k < 4); eb = 1'b1; ed = 1'b0;
         end else if (k < 10) begin
            el = 1'b0; eb = 1'b0; ed = 1'b0;
         end else begin
            j  = k - 10;
            el = (j < 24) && ((j % 8) < 4);
            eb = (j < 24);
            ed = (j == 24);
         end
         n_checks++;
         if ({led4, busy4, done4} !== {el, eb, ed}) begin
            n_fail++; $display("FAIL reset_mid k=%0d got=%b exp=%b", k, {led4, busy4, done4}, {el, eb, ed});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic el, eb, ed;
      int j;
      @(negedge clk);
      start2 = 1'b1; count2 = 4'd1;
      for (int k = 0; k < 13; k++) begin
         @(posedge clk);
         @(negedge clk);
         start2 = 1'b0;
         // Second request is sampled at E5, the edge where o_Done is high.
         if (k == 4) start2 = 1'b1;
         if (k < 5) begin
            el = (k < 2); eb = (k < 4); ed = (k == 4);
         end else begin
            j  = k - 5;
            el = (j < 2); eb = (j < 4); ed = (j == 4);
         end
         n_checks++;
         if ({led2, busy2, done2} !== {el, eb, ed}) begin
            n_fail++; $display("FAIL back_to_back k=%0d got=%b exp=%b", k, {led2, busy2, done2}, {el, eb, ed});
         end
      end
   endtask

   task automatic test_degenerate();
      logic el, eb, ed;
      @(negedge clk);
      start1 = 1'b1; count1 = 4'd15;
      for (int k = 0; k < 33; k++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         el = (k < 30) && ((k % 2) == 0);
         eb = (k < 30);
         ed = (k == 30);
         n_checks++;
         if ({led1, busy1, done1} !== {el, eb, ed}) begin
            n_fail++; $display("FAIL degenerate_p1 k=%0d got=%b exp=%b", k, {led1, busy1, done1}, {el, eb, ed});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_degenerate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
